// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of one iCE40 UP5K SPRAM bank (16K x 16).
// Round-robin with a bounded burst lock, registered SPRAM command and a 2-cycle read return.
module spram_arbiter #(
    parameter int unsigned LOCK_MAX   = 16,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_lock,
    input  logic [13:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic [3:0]  a_mask,
    output logic        a_gnt,
    output logic        a_rvalid,

    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [13:0] b_addr,
    input  logic [15:0] b_wdata,
    input  logic [3:0]  b_mask,
    output logic        b_gnt,
    output logic        b_rvalid,

    output logic [15:0] rdata,

    output logic [13:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic [3:0]  ram_mask,
    output logic        ram_wren,
    output logic        ram_cs,
    input  logic [15:0] ram_rdata
);

    localparam logic [7:0] LockMax = 8'(LOCK_MAX);

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

    // Arbitration state
    port_e      last_q, last_d;
    port_e      owner_q, owner_d;
    logic       locked_q, locked_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;

    // Command register and read tags
    logic [13:0] ram_addr_q;
    logic [15:0] ram_wdata_q;
    logic [3:0]  ram_mask_q;
    logic        ram_wren_q;
    logic        ram_cs_q;
    logic [1:0]  a_rd_q;
    logic [1:0]  b_rd_q;

    // Combinational decision
    port_e       winner;
    logic        grant;
    logic        contested;
    logic        lock_live;
    logic        win_we;
    logic        win_lock;
    logic [13:0] win_addr;
    logic [15:0] win_wdata;
    logic [3:0]  win_mask;
    logic [7:0]  cnt_base;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    always_comb begin
        contested = a_req & b_req;
        grant     = a_req | b_req;
        lock_live = locked_q && (lock_cnt_q < LockMax);
        winner    = a_req ? PortA : PortB;
        if (FIXED_PRIO == 0 && contested) begin
            if (lock_live) begin
                winner = owner_q;
            end else begin
                winner = (last_q == PortA) ? PortB : PortA;
            end
        end
    end

    always_comb begin
        if (winner == PortA) begin
            win_we    = a_we;
            win_lock  = a_lock;
            win_addr  = a_addr;
            win_wdata = a_wdata;
            win_mask  = a_mask;
        end else begin
            win_we    = b_we;
            win_lock  = b_lock;
            win_addr  = b_addr;
            win_wdata = b_wdata;
            win_mask  = b_mask;
        end
    end

    assign a_gnt = grant && (winner == PortA);
    assign b_gnt = grant && (winner == PortB);

    // ------------------------------------------------------------------
    // Next-state for fairness / lock tracking
    // ------------------------------------------------------------------
    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        // A grant to the non-owner restarts the burst count from zero.
        cnt_base   = (locked_q && owner_q == winner) ? lock_cnt_q : 8'd0;
        if (grant) begin
            last_d = winner;
            if (win_lock) begin
                locked_d   = 1'b1;
                owner_d    = winner;
                lock_cnt_d = (contested && cnt_base < LockMax) ? cnt_base + 8'd1 : cnt_base;
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= PortB;
            owner_q    <= PortA;
            locked_q   <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            last_q     <= last_d;
            owner_q    <= owner_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // SPRAM command register: address/data/mask hold while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q  <= 14'd0;
            ram_wdata_q <= 16'd0;
            ram_mask_q  <= 4'd0;
            ram_wren_q  <= 1'b0;
            ram_cs_q    <= 1'b0;
        end else begin
            ram_cs_q   <= grant;
            ram_wren_q <= grant & win_we;
            if (grant) begin
                ram_addr_q  <= win_addr;
                ram_wdata_q <= win_wdata;
                ram_mask_q  <= win_mask;
            end
        end
    end

    // Read tags: stage 0 = command on pins, stage 1 = data on DATAOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rd_q <= 2'b00;
            b_rd_q <= 2'b00;
        end else begin
            a_rd_q <= {a_rd_q[0], a_gnt & ~a_we};
            b_rd_q <= {b_rd_q[0], b_gnt & ~b_we};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_mask  = ram_mask_q;
    assign ram_wren  = ram_wren_q;
    assign ram_cs    = ram_cs_q;

    assign a_rvalid  = a_rd_q[1];
    assign b_rvalid  = b_rd_q[1];
    assign rdata     = ram_rdata;

endmodule
